// File: rtl/ansi_csi_decoder_pkg.sv
// Shared byte and command codes for the ANSI CSI decoder and its consumers.
// The same codes are used by the character/VGA text engine downstream.
package ansi_csi_decoder_pkg;

  localparam logic [7:0] CHAR_ESC         = 8'h1B;
  localparam logic [7:0] CHAR_LEFTBRACKET = 8'h5B;
  localparam logic [7:0] CHAR_SEMI        = 8'h3B;
  localparam logic [7:0] CHAR_CAN         = 8'h18;
  localparam logic [7:0] CHAR_SUB         = 8'h1A;

  localparam logic [7:0] CMD_UP    = 8'd2;
  localparam logic [7:0] CMD_DOWN  = 8'd10;
  localparam logic [7:0] CMD_LEFT  = 8'd12;
  localparam logic [7:0] CMD_RIGHT = 8'd14;
  localparam logic [7:0] CMD_CUP   = 8'd16;
  localparam logic [7:0] CMD_ED    = 8'd18;
  localparam logic [7:0] CMD_EL    = 8'd20;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Final bytes 'A'..'D' map onto the four cursor-move commands.
  function automatic logic [7:0] arrow_cmd(input logic [7:0] b);
    case (b)
      8'h41:   return CMD_UP;
      8'h42:   return CMD_DOWN;
      8'h43:   return CMD_RIGHT;
      default: return CMD_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/ansi_rx_fifo.sv
// First-word-fall-through synchronous FIFO with asynchronous reset.
// A read and a write in the same cycle are both honoured even when full.
module ansi_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_do_rd   = i_rd_en && !o_empty;
  assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ansi_csi_decoder.sv
// UART-side ANSI CSI parser: buffers bytes, decodes cursor/erase sequences with
// numeric arguments and emits characters or commands over a valid/ready port.
module ansi_csi_decoder
  import ansi_csi_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_PARAMS  = 2,
  parameter int ARG_W       = 8,
  parameter int REPEAT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxDataInValid,
  input  logic [7:0]       rxDataIn,
  output logic             rxDataInReady,
  output logic             rxOverflow,
  output logic             outValid,
  input  logic             outReady,
  output logic             outIsCmd,
  output logic [7:0]       outData,
  output logic [ARG_W-1:0] outArg0,
  output logic [ARG_W-1:0] outArg1,
  output logic             seqActive
);

  // Handshake: an item transfers on a rising edge where outValid && outReady;
  // while outValid && !outReady every output field holds its value.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ESC = 2'd1, ST_CSI = 2'd2} state_t;

  localparam int IDX_W = $clog2(NUM_PARAMS + 1);
  localparam int ACC_W = ARG_W + 4;
  localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'({ARG_W{1'b1}});
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PARAMS);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [ARG_W-1:0] ARG_ONE  = ARG_W'(1);
  localparam logic [ARG_W-1:0] ARG_TWO  = ARG_W'(2);
  localparam int P1_SEL = (NUM_PARAMS > 1) ? 1 : 0;

  function automatic logic [ARG_W-1:0] sat_mac(input logic [ARG_W-1:0] p, input logic [3:0] d);
    logic [ACC_W-1:0] v;
    v = ACC_W'(p) * ACC_W'(10) + ACC_W'(d);
    return (v > ACC_MAX) ? '1 : v[ARG_W-1:0];
  endfunction

  state_t           r_state, w_state_nxt;
  logic [ARG_W-1:0] r_param [NUM_PARAMS];
  logic [IDX_W-1:0] r_idx;
  logic             r_discard;
  logic [ARG_W-1:0] r_rep_cnt;
  logic             r_out_valid, r_out_is_cmd, r_overflow;
  logic [7:0]       r_out_data;
  logic [ARG_W-1:0] r_out_arg0, r_out_arg1;

  logic             w_fifo_empty, w_fifo_full, w_wr_en;
  logic [7:0]       w_byte;
  logic             w_pop, w_accept;
  logic [ARG_W-1:0] w_p0, w_p1, w_p0_min1, w_p1_min1;
  logic             w_emit, w_emit_cmd, w_clr_params, w_digit, w_semi, w_set_discard;
  logic [7:0]       w_emit_data;
  logic [ARG_W-1:0] w_emit_arg0, w_emit_arg1, w_emit_rep;

  assign rxDataInReady = !w_fifo_full;
  assign w_wr_en       = rxDataInValid && rxDataInReady;

  ansi_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_data (rxDataIn),
    .i_rd_en   (w_pop),
    .o_rd_data (w_byte),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  // A pending repeat burst owns the output register until it has drained.
  assign w_accept = r_out_valid && outReady;
  assign w_pop    = !w_fifo_empty && (!r_out_valid || outReady) && (r_rep_cnt == '0);

  assign w_p0      = r_param[0];
  assign w_p1      = (NUM_PARAMS > 1) ? r_param[P1_SEL] : '0;
  assign w_p0_min1 = (w_p0 == '0) ? ARG_ONE : w_p0;
  assign w_p1_min1 = (w_p1 == '0) ? ARG_ONE : w_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_emit        = 1'b0;
    w_emit_cmd    = 1'b0;
    w_emit_data   = w_byte;
    w_emit_arg0   = '0;
    w_emit_arg1   = '0;
    w_emit_rep    = '0;
    w_clr_params  = 1'b0;
    w_digit       = 1'b0;
    w_semi        = 1'b0;
    w_set_discard = 1'b0;
    if (w_pop) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte == CHAR_ESC) w_state_nxt = ST_ESC;
          else                    w_emit = 1'b1;
        end
        ST_ESC: begin
          if (w_byte == CHAR_LEFTBRACKET) begin
            w_state_nxt  = ST_CSI;
            w_clr_params = 1'b1;
          end else if (w_byte != CHAR_ESC) begin
            w_emit      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CSI: begin
          if (is_digit(w_byte))                                w_digit = 1'b1;
          else if (w_byte == CHAR_SEMI)                        w_semi = 1'b1;
          else if (w_byte == CHAR_CAN || w_byte == CHAR_SUB)   w_state_nxt = ST_IDLE;
          else if (w_byte == CHAR_ESC)                         w_state_nxt = ST_ESC;
          else if (w_byte < 8'h20)                             w_emit = 1'b1;
          else if (w_byte < 8'h40)                             w_set_discard = 1'b1;
          else if (w_byte < 8'h7F) begin
            w_state_nxt = ST_IDLE;
            if (!r_discard) begin
              case (w_byte)
                "A", "B", "C", "D": begin
                  w_emit      = 1'b1;
                  w_emit_cmd  = 1'b1;
                  w_emit_data = arrow_cmd(w_byte);
                  if (REPEAT_MODE != 0) begin
                    w_emit_arg0 = ARG_ONE;
                    w_emit_rep  = w_p0_min1 - ARG_ONE;
                  end else begin
                    w_emit_arg0 = w_p0_min1;
                  end
                end
                "H", "f": begin
                  w_emit      = 1'b1;
                  w_emit_cmd  = 1'b1;
                  w_emit_data = CMD_CUP;
                  w_emit_arg0 = w_p0_min1;
                  w_emit_arg1 = w_p1_min1;
                end
                "J", "K": begin
                  // Erase modes above 2 are not defined; such sequences are dropped.
                  if (w_p0 <= ARG_TWO) begin
                    w_emit      = 1'b1;
                    w_emit_cmd  = 1'b1;
                    w_emit_data = (w_byte == "J") ? CMD_ED : CMD_EL;
                    w_emit_arg0 = w_p0;
                  end
                end
                default: w_emit = 1'b1;
              endcase
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_discard <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) r_param[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (w_clr_params)
          r_param[i] <= '0;
        else if (w_digit && r_idx == IDX_W'(i))
          r_param[i] <= sat_mac(r_param[i], w_byte[3:0]);
      end
      if (w_clr_params)                      r_idx <= '0;
      else if (w_semi && r_idx != IDX_LAST)  r_idx <= r_idx + IDX_ONE;
      if (w_clr_params)       r_discard <= 1'b0;
      else if (w_set_discard) r_discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_is_cmd <= 1'b0;
      r_out_data   <= '0;
      r_out_arg0   <= '0;
      r_out_arg1   <= '0;
      r_rep_cnt    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (rxDataInValid && !rxDataInReady) r_overflow <= 1'b1;
      if (w_pop && w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_is_cmd <= w_emit_cmd;
        r_out_data   <= w_emit_data;
        r_out_arg0   <= w_emit_arg0;
        r_out_arg1   <= w_emit_arg1;
        r_rep_cnt    <= w_emit_rep;
      end else if (w_accept) begin
        // During a burst the register re-presents the same single-step command.
        if (r_rep_cnt != '0) r_rep_cnt <= r_rep_cnt - ARG_ONE;
        else                 r_out_valid <= 1'b0;
      end
    end
  end

  assign outValid   = r_out_valid;
  assign outIsCmd   = r_out_is_cmd;
  assign outData    = r_out_data;
  assign outArg0    = r_out_arg0;
  assign outArg1    = r_out_arg1;
  assign rxOverflow = r_overflow;
  assign seqActive  = (r_state != ST_IDLE);

endmodule

// File: doc/ansi_csi_decoder.md
Name: ansi_csi_decoder

Overview:
- Parametrised successor to the UART-side ANSI escape filter. It sits between the UART receiver and the character/VGA text engine.
- Buffers received bytes in an internal FIFO and parses full CSI sequences (ESC '[' params ';' final), including numeric parameters.
- Emits either plain characters or decoded cursor/erase commands with arguments over a valid/ready output handshake.
- Adds three things the previous filter lacked: backpressure, repeat counts, and cursor positioning.

Parameters:
- FIFO_DEPTH, 8, input FIFO entries (power of 2, ≥2).
- NUM_PARAMS, 2, numeric parameters captured per sequence (1..4); extra parameters are parsed and discarded.
- ARG_W, 8, width of each argument; accumulation saturates at 2^ARG_W-1.
- REPEAT_MODE, 0, selects how arrow counts are delivered. 0: one command carrying its count in outArg0. 1: N successive single-step commands with outArg0=1, compatible with the legacy consumer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rxDataInValid  in  1  input byte strobe.
- rxDataIn  in  8  input byte.
- rxDataInReady  out  1  FIFO not full; a byte is written only when valid&ready.
- rxOverflow  out  1  sticky; set when valid && !ready; cleared only by reset.
- outValid  out  1  output item available.
- outReady  in  1  consumer accepts the item when valid&ready.
- outIsCmd  out  1  1 = outData is a command code; 0 = character.
- outData  out  8  character or command code.
- outArg0  out  ARG_W  count / row / erase mode.
- outArg1  out  ARG_W  column (CUP only, else 0).
- seqActive  out  1  parser is not in IDLE (debug).

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, FIFO empty, rxDataInReady=1 after the reset cycle, rxOverflow=0, outValid=0, outIsCmd=0, outData=0, outArg0=0, outArg1=0, seqActive=0.
- Reset mid-sequence discards any partial sequence and all buffered bytes.
- FIFO is first-word-fall-through. Simultaneous read and write when full is allowed and keeps the count unchanged.
- Parser pops the FIFO head only when the output register is empty or being accepted this cycle, and no repeat burst is pending.
- Plain-character latency: written at cycle t, outValid at t+2. Back-to-back throughput is 1 byte/cycle with outReady held high.
- Output register holds every field stable while outValid && !outReady.
- IDLE: ESC (0x1B) -> ESC state, no output. Any other byte is emitted as a character.
- ESC state:
  - '[' -> CSI; clear all params and the param index.
  - ESC -> stay in ESC.
  - Any other byte -> emit that byte as a character, go to IDLE. The ESC itself is dropped.
- CSI state:
  - '0'-'9': param[idx] = sat(param[idx]*10 + digit).
  - ';': idx++ (saturating at NUM_PARAMS; later params are ignored).
  - 0x3C-0x3F (private marker) or 0x20-0x2F (intermediate): set discard flag.
  - CAN 0x18 / SUB 0x1A: abort to IDLE, no output.
  - ESC: restart in ESC state.
  - Other C0 byte (<0x20): emitted as a character, state unchanged.
  - 0x40-0x7E (final byte): dispatch, then go to IDLE.
- Dispatch (p0/p1 = param0/param1; a missing or 0 value means default):
  - A/B/C/D -> CMD_UP 2 / CMD_DOWN 10 / CMD_RIGHT 14 / CMD_LEFT 12, count=max(p0,1).
  - H or f -> CMD_CUP 16, arg0=max(p0,1), arg1=max(p1,1).
  - J -> CMD_ED 18, arg0=p0 (values >2 -> sequence dropped).
  - K -> CMD_EL 20, arg0=p0 (same rule).
  - Discard flag set -> no output.
  - Any other final byte -> emitted as a character, as before.
- REPEAT_MODE=1 for arrows: a down-counter loaded with count-1 re-issues the same command after each accepted item. FIFO reads are stalled until the counter reaches 0.
- A count at saturation (255) is valid. No wrap-around anywhere.
- Output is never lost; a full FIFO backpressures via rxDataInReady.

Decomposition:
- Shared header keycharcmdcodes.vh: CHAR_ESC, CHAR_LEFTBRACKET, CHAR_SEMI, CHAR_CAN, CHAR_SUB, CMD_UP/DOWN/LEFT/RIGHT, plus the new CMD_CUP/CMD_ED/CMD_EL.
- Parser state encodings are local.
- One sub-module, ansi_rx_fifo: parametrised FWFT synchronous FIFO with async reset. This replaces the vendor IP so the block can be depth-parametrised and simulated portably.

Test Plan:
- "Hi" with outReady=1 -> chars 0x48 then 0x69, first outValid 2 cycles after first write, back-to-back.
- ESC [ 1 2 ; 4 0 H -> one item: outIsCmd=1, outData=16, outArg0=12, outArg1=40. ESC [ H -> arg0=1, arg1=1.
- REPEAT_MODE=0: ESC [ 3 A -> one cmd 2, arg0=3. REPEAT_MODE=1: the same input yields three cmd-2 items with arg0=1, and a following 'x' appears only after the third item.
- ESC [ 9 9 9 C with ARG_W=8 -> cmd 14, arg0=255. ESC [ ? 2 5 h -> no output. ESC [ 1 CAN -> no output. ESC x -> char 'x'. ESC [ Z -> char 'Z'.
- outReady=0 while 10 bytes are offered (FIFO_DEPTH=8) -> rxDataInReady falls, held output stays stable, rxOverflow=1 only if valid is forced while not ready. Releasing outReady drains all accepted bytes in order.
- Assert reset mid-sequence (after ESC [ 5), then send 'A' -> char 0x41, not a command. Reset drives all outputs to 0 without waiting for a clock edge.
